ant_pheromone_table: RTL and testbench
======================================

ANT_PHEROMONE_TABLE -- requirements
Module: ant_pheromone_table

Interface
REQ-001 Parameter NODES, default 16: number of destination rows.
REQ-002 Parameter PORTS, default 5: router ports; port 0 is local, ports 1..PORTS-1 are neighbours.
REQ-003 Parameter PH_W, default 8: pheromone width, unsigned.
REQ-004 Parameters PH_MIN=0, PH_MAX=255, PH_INIT=128: saturation bounds and reset value.
REQ-005 Parameters DELTA_INC=4, DELTA_DEC=1: reinforcement and penalty steps per update.
REQ-006 Parameters EVAP_PERIOD=1024, EVAP_STEP=1: cycles between evaporation sweeps, and the decrement per sweep.
REQ-007 i_clk  in  1  sole clock, rising edge.
REQ-008 i_reset_n  in  1  asynchronous, active-low reset.
REQ-009 i_lookup_valid  in  1  lookup request.
REQ-010 i_lookup_dest  in  clog2(NODES)  lookup destination.
REQ-011 i_lookup_parent  in  clog2(PORTS)  arrival port, excluded from selection.
REQ-012 i_update_valid  in  1  update request.
REQ-013 i_update_dest  in  clog2(NODES)  row to update.
REQ-014 i_update_port  in  clog2(PORTS)  port to reinforce.
REQ-015 o_ready  out  1  requests accepted this cycle.
REQ-016 o_next_valid  out  1  lookup result valid.
REQ-017 o_next_output  out  PORTS  one-hot selected output port.
REQ-018 o_next_value  out  PH_W  pheromone of the selected port.

Function
REQ-019 Storage: one PH_W register per (dest, neighbour port 1..PORTS-1); port 0 has no storage.
REQ-020 A lookup is accepted when i_lookup_valid & o_ready; the result appears on the next cycle with o_next_valid=1 for exactly one cycle.
REQ-021 Selection: the neighbour p != parent with the strictly greatest value; ties go to the lowest index.
REQ-022 If every eligible neighbour holds PH_MIN, o_next_output selects port 0 and o_next_value=PH_MIN.
REQ-023 When no result is valid, o_next_output=0 and o_next_value=0.
REQ-024 An update is accepted when i_update_valid & o_ready.
REQ-025 On the cycle after acceptance: entry[dest][port] becomes min(v+DELTA_INC, PH_MAX) and every other neighbour in that row becomes max(v-DELTA_DEC, PH_MIN).
REQ-026 Update arithmetic is computed at PH_W+1 bits before saturation; no wrap-around is permitted.
REQ-027 An update with i_update_port=0 applies only the penalty to all neighbours.
REQ-028 A simultaneous lookup and update to the same row reads the pre-update values (read-before-write).
REQ-029 FSM states: IDLE, SWEEP.
REQ-030 IDLE: the evaporation counter increments each cycle; at EVAP_PERIOD-1 it clears and the FSM goes to SWEEP.
REQ-031 SWEEP: one row per cycle, rows 0..NODES-1, each entry becomes max(v-EVAP_STEP, PH_MIN); after the last row the FSM returns to IDLE.
REQ-032 o_ready=1 in IDLE only; it is 0 throughout SWEEP, including the transition cycle into SWEEP.
REQ-033 A request accepted on the last IDLE cycle completes before the first sweep write.

Reset
REQ-034 While i_reset_n=0: all entries=PH_INIT, FSM=IDLE, evaporation counter=0, o_next_valid=0, o_next_output=0, o_next_value=0.
REQ-035 o_ready=1 from the first cycle after reset deassertion.
REQ-036 Reset asserted mid-SWEEP or mid-lookup abandons the operation; no partial result is produced.

Structure
REQ-037 The shared package holds the PH_W-derived pheromone typedef, port/dest index typedefs, the FSM state enum and default parameter constants.
REQ-038 Selection logic is one sub-module, ant_argmax_select (PORTS, PH_W), combinational, tie-to-lowest, with parent exclusion.

Verification
REQ-039 Reset, then lookup dest 3 / parent 1 -> next cycle o_next_output=00100 (port 2, lowest tie), o_next_value=128.
REQ-040 Update dest 3 / port 4 applied 40 times -> entry[3][4]=255 (saturated), others=88; lookup parent 4 -> port 1, value 88.
REQ-041 Update dest 0 / port 0 applied 200 times -> all row-0 entries=0; lookup -> o_next_output=00001 (port 0), value 0.
REQ-042 Same-cycle update and lookup on dest 5 / port 2 -> lookup returns 128; following lookup returns port 2, value 132.
REQ-043 EVAP_PERIOD=8, NODES=4 -> o_ready low for exactly 4 cycles every 8+4; all entries drop by 1 per sweep.
REQ-044 Reset asserted during the second sweep row -> all entries=128, FSM=IDLE, o_next_valid=0.

Source files
------------

// File: rtl/ant_pheromone_table_pkg.sv
// Shared types and default constants for the ant-colony pheromone table.
// The FSM enum and the default-sized index types live here.
package ant_pheromone_table_pkg;

  localparam int NODES_D       = 16;
  localparam int PORTS_D       = 5;
  localparam int PH_W_D        = 8;
  localparam int PH_MIN_D      = 0;
  localparam int PH_MAX_D      = 255;
  localparam int PH_INIT_D     = 128;
  localparam int DELTA_INC_D   = 4;
  localparam int DELTA_DEC_D   = 1;
  localparam int EVAP_PERIOD_D = 1024;
  localparam int EVAP_STEP_D   = 1;

  typedef logic [PH_W_D-1:0]          ph_t;
  typedef logic [$clog2(NODES_D)-1:0] dest_t;
  typedef logic [$clog2(PORTS_D)-1:0] port_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

endpackage

// File: rtl/ant_argmax_select.sv
// Combinational argmax over neighbour ports 1..PORTS-1, skipping the parent.
// Ties go to the lowest index; nothing above zero selects port 0.
module ant_argmax_select #(
  parameter int PORTS = 5,
  parameter int PH_W  = 8
) (
  input  logic [(PORTS-1)*PH_W-1:0] i_vals,
  input  logic [$clog2(PORTS)-1:0]  i_parent,
  output logic [PORTS-1:0]          o_onehot,
  output logic [PH_W-1:0]           o_value
);

  int              best_p;
  logic [PH_W-1:0] best_v;
  logic [PH_W-1:0] cur_v;

  always_comb begin
    best_p = 0;
    best_v = '0;
    cur_v  = '0;
    for (int p = 1; p < PORTS; p++) begin
      cur_v = i_vals[(p-1)*PH_W +: PH_W];
      if (p != int'(i_parent) && cur_v > best_v) begin
        best_v = cur_v;
        best_p = p;
      end
    end
    o_value = best_v;
    for (int p = 0; p < PORTS; p++) begin
      o_onehot[p] = (p == best_p);
    end
  end

endmodule

// File: rtl/ant_pheromone_table.sv
// Per-destination pheromone table with reinforcement updates,
// argmax next-hop lookup and periodic evaporation sweeps.
module ant_pheromone_table
  import ant_pheromone_table_pkg::*;
#(
  parameter int NODES       = NODES_D,
  parameter int PORTS       = PORTS_D,
  parameter int PH_W        = PH_W_D,
  parameter int PH_MIN      = PH_MIN_D,
  parameter int PH_MAX      = PH_MAX_D,
  parameter int PH_INIT     = PH_INIT_D,
  parameter int DELTA_INC   = DELTA_INC_D,
  parameter int DELTA_DEC   = DELTA_DEC_D,
  parameter int EVAP_PERIOD = EVAP_PERIOD_D,
  parameter int EVAP_STEP   = EVAP_STEP_D
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_lookup_valid,
  input  logic [$clog2(NODES)-1:0] i_lookup_dest,
  input  logic [$clog2(PORTS)-1:0] i_lookup_parent,
  input  logic                     i_update_valid,
  input  logic [$clog2(NODES)-1:0] i_update_dest,
  input  logic [$clog2(PORTS)-1:0] i_update_port,
  output logic                     o_ready,
  output logic                     o_next_valid,
  output logic [PORTS-1:0]         o_next_output,
  output logic [PH_W-1:0]          o_next_value
);

  localparam int DW = $clog2(NODES);
  localparam int EW = $clog2(EVAP_PERIOD);

  typedef logic [PH_W-1:0] ph_w_t;

  ph_w_t tab_q [NODES][1:PORTS-1];
  ph_w_t tab_d [NODES][1:PORTS-1];

  state_e          state_q, state_d;
  logic [EW-1:0]   evap_q, evap_d;
  logic [DW-1:0]   row_q, row_d;

  logic            nv_q;
  logic [PORTS-1:0] no_q;
  ph_w_t           nval_q;

  logic                     lk_acc;
  logic                     upd_acc;
  logic [(PORTS-1)*PH_W-1:0] row_flat;
  logic [PORTS-1:0]         sel_oh;
  ph_w_t                    sel_v;
  logic [PORTS-1:0]         res_oh;
  ph_w_t                    res_v;

  function automatic ph_w_t sat_inc(input ph_w_t v);
    logic [PH_W:0] s;
    s = {1'b0, v} + (PH_W+1)'(DELTA_INC);
    if (s > (PH_W+1)'(PH_MAX)) return ph_w_t'(PH_MAX);
    return s[PH_W-1:0];
  endfunction

  function automatic ph_w_t sat_dec(input ph_w_t v,
                                    input int   step);
    logic [PH_W:0] s;
    s = {1'b0, v} - (PH_W+1)'(step);
    if (s[PH_W] || s[PH_W-1:0] < ph_w_t'(PH_MIN))
      return ph_w_t'(PH_MIN);
    return s[PH_W-1:0];
  endfunction

  assign lk_acc  = i_lookup_valid & o_ready;
  assign upd_acc = i_update_valid & o_ready;

  always_comb begin
    state_d = state_q;
    evap_d  = evap_q;
    row_d   = row_q;
    o_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (evap_q == EW'(EVAP_PERIOD-1)) begin
          evap_d  = '0;
          row_d   = '0;
          state_d = SWEEP;
        end else begin
          evap_d = evap_q + EW'(1);
        end
      end
      SWEEP: begin
        if (row_q == DW'(NODES-1)) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Updates and sweeps never coincide: updates need o_ready.
  always_comb begin
    tab_d = tab_q;
    if (upd_acc) begin
      for (int p = 1; p < PORTS; p++) begin
        if (p == int'(i_update_port))
          tab_d[i_update_dest][p] = sat_inc(tab_q[i_update_dest][p]);
        else
          tab_d[i_update_dest][p] =
            sat_dec(tab_q[i_update_dest][p], DELTA_DEC);
      end
    end
    if (state_q == SWEEP) begin
      for (int p = 1; p < PORTS; p++) begin
        tab_d[row_q][p] = sat_dec(tab_q[row_q][p], EVAP_STEP);
      end
    end
  end

  always_comb begin
    row_flat = '0;
    for (int p = 1; p < PORTS; p++) begin
      row_flat[(p-1)*PH_W +: PH_W] = tab_q[i_lookup_dest][p];
    end
  end

  ant_argmax_select #(
    .PORTS (PORTS),
    .PH_W  (PH_W)
  ) u_sel (
    .i_vals   (row_flat),
    .i_parent (i_lookup_parent),
    .o_onehot (sel_oh),
    .o_value  (sel_v)
  );

  // A row sitting entirely at the floor routes to the local port.
  always_comb begin
    res_oh = sel_oh;
    res_v  = sel_v;
    if (sel_v <= ph_w_t'(PH_MIN)) begin
      res_oh    = '0;
      res_oh[0] = 1'b1;
      res_v     = ph_w_t'(PH_MIN);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      evap_q  <= '0;
      row_q   <= '0;
      nv_q    <= 1'b0;
      no_q    <= '0;
      nval_q  <= '0;
      for (int n = 0; n < NODES; n++) begin
        for (int p = 1; p < PORTS; p++) begin
          tab_q[n][p] <= ph_w_t'(PH_INIT);
        end
      end
    end else begin
      state_q <= state_d;
      evap_q  <= evap_d;
      row_q   <= row_d;
      nv_q    <= lk_acc;
      no_q    <= lk_acc ? res_oh : '0;
      nval_q  <= lk_acc ? res_v : '0;
      tab_q   <= tab_d;
    end
  end

  assign o_next_valid  = nv_q;
  assign o_next_output = no_q;
  assign o_next_value  = nval_q;

endmodule

// File: tb/tb_ant_pheromone_table.sv
// Directed bench: default-size table plus a small fast-evaporating one.
module tb_ant_pheromone_table;

  logic clk;
  int   n_vec = 0;
  int   n_bad = 0;

  logic       a_rst_n, a_lv, a_uv;
  logic [3:0] a_ld, a_ud;
  logic [2:0] a_lp, a_up;
  logic       a_rdy, a_nv;
  logic [4:0] a_no;
  logic [7:0] a_nval;

  logic       b_rst_n, b_lv, b_uv;
  logic [1:0] b_ld, b_ud;
  logic [2:0] b_lp, b_up;
  logic       b_rdy, b_nv;
  logic [4:0] b_no;
  logic [7:0] b_nval;

  ant_pheromone_table u_a (
    .i_clk           (clk),
    .i_reset_n       (a_rst_n),
    .i_lookup_valid  (a_lv),
    .i_lookup_dest   (a_ld),
    .i_lookup_parent (a_lp),
    .i_update_valid  (a_uv),
    .i_update_dest   (a_ud),
    .i_update_port   (a_up),
    .o_ready         (a_rdy),
    .o_next_valid    (a_nv),
    .o_next_output   (a_no),
    .o_next_value    (a_nval)
  );

  ant_pheromone_table #(
    .NODES       (4),
    .EVAP_PERIOD (8)
  ) u_b (
    .i_clk           (clk),
    .i_reset_n       (b_rst_n),
    .i_lookup_valid  (b_lv),
    .i_lookup_dest   (b_ld),
    .i_lookup_parent (b_lp),
    .i_update_valid  (b_uv),
    .i_update_dest   (b_ud),
    .i_update_port   (b_up),
    .o_ready         (b_rdy),
    .o_next_valid    (b_nv),
    .o_next_output   (b_no),
    .o_next_value    (b_nval)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic lk_a(input string tag,
                      input logic [3:0] d,
                      input logic [2:0] par,
                      input logic [4:0] eoh,
                      input logic [7:0] ev);
    a_lv = 1'b1;
    a_ld = d;
    a_lp = par;
    tick();
    a_lv = 1'b0;
    chk(tag, a_nv, 1);
    chk(tag, a_no, eoh);
    chk(tag, a_nval, ev);
  endtask

  initial begin
    clk = 0;
    a_rst_n = 0; a_lv = 0; a_uv = 0;
    a_ld = 0; a_ud = 0; a_lp = 0; a_up = 0;
    b_rst_n = 0; b_lv = 0; b_uv = 0;
    b_ld = 0; b_ud = 0; b_lp = 0; b_up = 0;
    tick();
    tick();
    chk("rst_nv", a_nv, 0);
    chk("rst_no", a_no, 0);
    chk("rst_val", a_nval, 0);
    a_rst_n = 1;
    #1;
    chk("rst_rdy", a_rdy, 1);

    lk_a("init_lk", 4'd3, 3'd1, 5'b00100, 8'd128);
    tick();
    chk("one_shot_v", a_nv, 0);
    chk("one_shot_o", a_no, 0);
    chk("one_shot_d", a_nval, 0);

    a_uv = 1; a_ud = 4'd3; a_up = 3'd4;
    for (int i = 0; i < 40; i++) tick();
    a_uv = 0;
    lk_a("reinf_p4", 4'd3, 3'd4, 5'b00010, 8'd88);
    lk_a("reinf_sat", 4'd3, 3'd0, 5'b10000, 8'd255);

    a_uv = 1; a_ud = 4'd0; a_up = 3'd0;
    for (int i = 0; i < 200; i++) tick();
    a_uv = 0;
    lk_a("floor_p0", 4'd0, 3'd0, 5'b00001, 8'd0);
    lk_a("floor_p2", 4'd0, 3'd2, 5'b00001, 8'd0);
    lk_a("row1_ok", 4'd1, 3'd0, 5'b00010, 8'd128);

    a_uv = 1; a_ud = 4'd5; a_up = 3'd2;
    a_lv = 1; a_ld = 4'd5; a_lp = 3'd0;
    tick();
    a_uv = 0; a_lv = 0;
    chk("rbw_v", a_nv, 1);
    chk("rbw_o", a_no, 5'b00010);
    chk("rbw_d", a_nval, 8'd128);
    lk_a("rbw_after", 4'd5, 3'd0, 5'b00100, 8'd132);
    lk_a("rbw_pen", 4'd5, 3'd2, 5'b00010, 8'd127);

    b_rst_n = 1;
    for (int k = 0; k <= 33; k++) begin
      b_lv = 0;
      b_uv = 0;
      chk("b_rdy", b_rdy, ((k % 12) < 8));
      if (k == 19) begin
        b_uv = 1; b_ud = 2'd0; b_up = 3'd1;
      end
      if (k == 24) begin
        b_lv = 1; b_ld = 2'd0; b_lp = 3'd0;
      end
      if (k == 25) begin
        chk("b_lk0_v", b_nv, 1);
        chk("b_lk0_o", b_no, 5'b00010);
        chk("b_lk0_d", b_nval, 8'd130);
        b_lv = 1; b_ld = 2'd3; b_lp = 3'd0;
      end
      if (k == 26) begin
        chk("b_lk3_v", b_nv, 1);
        chk("b_lk3_o", b_no, 5'b00010);
        chk("b_lk3_d", b_nval, 8'd126);
      end
      if (k == 27) chk("b_idle_v", b_nv, 0);
      if (k == 33) begin
        b_rst_n = 0;
        #1;
        chk("b_rst_v", b_nv, 0);
        chk("b_rst_o", b_no, 0);
        chk("b_rst_d", b_nval, 0);
        chk("b_rst_rdy", b_rdy, 1);
      end else begin
        tick();
      end
    end
    tick();
    b_rst_n = 1;
    b_lv = 1; b_ld = 2'd0; b_lp = 3'd0;
    tick();
    chk("b_post_v", b_nv, 1);
    chk("b_post_o", b_no, 5'b00010);
    chk("b_post_d", b_nval, 8'd128);
    b_ld = 2'd1; b_lp = 3'd1;
    tick();
    b_lv = 0;
    chk("b_post1_o", b_no, 5'b00100);
    chk("b_post1_d", b_nval, 8'd128);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
